tea_lane_scheduler: RTL and testbench

//  Parametrised round-robin dispatcher over NUM_LANES iterative TEA decrypt lanes.

---
 rtl/tea_lane_scheduler_pkg.sv | 36 +++
 rtl/tea_lane_scheduler_if.sv | 34 +++
 rtl/tea_lane_scheduler_lane.sv | 86 ++++++++
 rtl/tea_lane_scheduler.sv | 89 ++++++++
 tb/tb_tea_lane_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tea_lane_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tea_lane_scheduler_pkg
// Shared definitions for the TEA lane scheduler:
//   - block/key widths and the TEA DELTA constant
//   - lane_state_t, the per-lane FSM encoding (also used as the lane debug output)
//   - tea_sum_init(): decrypt sum start value, DELTA*rounds mod 2^32
//   - tea_mix(): the TEA half-round mixing term
// No ports (package).
// -----------------------------------------------------------------------------
package tea_lane_scheduler_pkg;

    localparam int          BLOCK_W   = 64;
    localparam int          KEY_W     = 128;
    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_RUN  = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    // Decrypt starts from the sum the encryptor finished with.
    function automatic logic [31:0] tea_sum_init(input int rounds);
        logic [63:0] prod;
        prod = 64'(TEA_DELTA) * 64'(unsigned'(rounds));
        return prod[31:0];
    endfunction

    function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                            input logic [31:0] sum,
                                            input logic [31:0] ka,
                                            input logic [31:0] kb);
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_lane_scheduler_if.sv
// -----------------------------------------------------------------------------
// tea_lane_scheduler_if
// Block-in / plaintext-out handshake bundle of the TEA lane scheduler.
//   in_valid, in_word64[63:0], in_key[127:0]  : source -> scheduler
//   in_ready                                   : scheduler -> source
//   out_valid, out_word64[63:0]                : scheduler -> sink
//   out_ready                                  : sink -> scheduler
// Modports: master = block source / plaintext sink, slave = scheduler.
//
// Handshake: a word moves on a rising clk edge where valid and ready are both
// high. A producer that raised valid keeps valid and its data stable until that
// edge; ready may be raised or dropped at any time and never depends on valid.
// -----------------------------------------------------------------------------
interface tea_lane_scheduler_if;

    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_word64;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_word64;

    modport master (
        output in_valid, in_word64, in_key, out_ready,
        input  in_ready, out_valid, out_word64
    );

    modport slave (
        input  in_valid, in_word64, in_key, out_ready,
        output in_ready, out_valid, out_word64
    );

endinterface

// File: rtl/tea_lane_scheduler_lane.sv
// -----------------------------------------------------------------------------
// tea_lane_scheduler_lane
// One iterative TEA decrypt lane: one round per enabled clk.
//   clk, rst   : clock, async active-high reset
//   ena        : global enable, low freezes the lane
//   start      : latch block/key and begin (only honoured in IDLE)
//   block, key : ciphertext (v0=[63:32], v1=[31:0]) and key (k0=[127:96]..k3)
//   ack        : result consumed, return to IDLE (only honoured in DONE)
//   state      : FSM state, IDLE -> RUN -> DONE -> IDLE
//   result     : current {v0,v1}; plaintext once state is DONE
// -----------------------------------------------------------------------------
module tea_lane_scheduler_lane
    import tea_lane_scheduler_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic [BLOCK_W-1:0] block,
    input  logic [KEY_W-1:0]  key,
    input  logic              ack,
    output lane_state_t       state,
    output logic [BLOCK_W-1:0] result
);

    localparam int              RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);
    localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);
    localparam logic [31:0]     SUM_INIT = tea_sum_init(ROUNDS);

    logic [31:0]      v0, v1, sum;
    logic [KEY_W-1:0] key_q;
    logic [RND_W-1:0] rnd;
    logic [31:0]      v1_next, v0_next;

    // Decrypt undoes the encrypt half-rounds in reverse: v1 first, then v0
    // using the already-updated v1, both within the same cycle.
    always_comb begin
        v1_next = v1 - tea_mix(v0, sum, key_q[63:32], key_q[31:0]);
        v0_next = v0 - tea_mix(v1_next, sum, key_q[127:96], key_q[95:64]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LANE_IDLE;
            v0    <= '0;
            v1    <= '0;
            sum   <= '0;
            key_q <= '0;
            rnd   <= '0;
        end else if (ena) begin
            case (state)
                LANE_IDLE: begin
                    if (start) begin
                        v0    <= block[63:32];
                        v1    <= block[31:0];
                        key_q <= key;
                        sum   <= SUM_INIT;
                        rnd   <= '0;
                        state <= LANE_RUN;
                    end
                end
                LANE_RUN: begin
                    v0  <= v0_next;
                    v1  <= v1_next;
                    sum <= sum - TEA_DELTA;
                    rnd <= rnd + RND_ONE;
                    if (rnd == LAST_RND) begin
                        state <= LANE_DONE;
                    end
                end
                LANE_DONE: begin
                    if (ack) begin
                        state <= LANE_IDLE;
                    end
                end
                default: state <= LANE_IDLE;
            endcase
        end
    end

    assign result = {v0, v1};

endmodule

// File: rtl/tea_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tea_lane_scheduler
// Round-robin dispatcher over NUM_LANES TEA decrypt lanes; plaintext leaves in
// the same order the ciphertext arrived.
//   clk, rst  : clock, async active-high reset
//   ena       : global enable, low freezes everything and blocks transfers
//   bus       : slave side of tea_lane_scheduler_if (block in, plaintext out)
//   inflight  : blocks accepted and not yet delivered, 0..NUM_LANES
// Blocks go to lane wr_ptr and come back from lane rd_ptr; both pointers walk
// the lanes in the same order, which is what preserves ordering.
// -----------------------------------------------------------------------------
module tea_lane_scheduler
    import tea_lane_scheduler_pkg::*;
#(
    parameter int  NUM_LANES = 8,
    parameter int  ROUNDS    = 32,
    localparam int PTR_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    tea_lane_scheduler_if.slave  bus,
    output logic [PTR_W:0]       inflight
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_LANES - 1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               run_q;
    logic               accept, deliver;
    lane_state_t        lane_state  [NUM_LANES];
    logic [BLOCK_W-1:0] lane_result [NUM_LANES];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // run_q keeps in_ready low while reset is applied and for the first cycle
    // after it, so the source never sees ready before the lanes are live.
    assign bus.in_ready   = ena & run_q & (lane_state[wr_ptr] == LANE_IDLE);
    assign bus.out_valid  = ena & (lane_state[rd_ptr] == LANE_DONE);
    assign bus.out_word64 = bus.out_valid ? lane_result[rd_ptr] : '0;

    assign accept  = bus.in_valid  & bus.in_ready;
    assign deliver = bus.out_valid & bus.out_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tea_lane_scheduler_lane #(
            .ROUNDS (ROUNDS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .start  (accept  && (wr_ptr == PTR_W'(i))),
            .block  (bus.in_word64),
            .key    (bus.in_key),
            .ack    (deliver && (rd_ptr == PTR_W'(i))),
            .state  (lane_state[i]),
            .result (lane_result[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            run_q    <= 1'b0;
        end else begin
            if (ena) begin
                run_q <= 1'b1;
            end
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deliver) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({accept, deliver})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tea_lane_scheduler
// Self-checking bench for tea_lane_scheduler (NUM_LANES=8, ROUNDS=32).
// Random plaintexts are encrypted with a loop-form TEA encryptor; the expected
// scheduler output is the original plaintext, queued in arrival order.
// -----------------------------------------------------------------------------
module tb_tea_lane_scheduler;
  import tea_lane_scheduler_pkg::*;

  localparam int NUM_LANES = 8;
  localparam int ROUNDS    = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] inflight;

  tea_lane_scheduler_if tif();

  tea_lane_scheduler #(
    .NUM_LANES (NUM_LANES),
    .ROUNDS    (ROUNDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .bus      (tif),
    .inflight (inflight)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: plain TEA encryption, ROUNDS rounds
  function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = pt[63:32];
    z = pt[31:0];
    s = 32'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: apply inputs for one cycle, report what transferred on the edge
  task automatic drive_cycle(input logic iv, input logic [63:0] ct, input logic [127:0] key,
                             input logic ordy, output logic acc, output logic dlv,
                             output logic [63:0] w);
    tif.in_valid  = iv;
    tif.in_word64 = ct;
    tif.in_key    = key;
    tif.out_ready = ordy;
    @(negedge clk);
    acc = tif.in_valid && tif.in_ready;
    dlv = tif.out_valid && tif.out_ready;
    w   = tif.out_word64;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    tif.in_valid  = 1'b0;
    tif.in_word64 = '0;
    tif.in_key    = '0;
    tif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", tif.in_ready); end
    checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", tif.out_valid); end
    checks++; if (tif.out_word64 !== 64'd0) begin errors++; $display("FAIL reset_out_word: got %h expected 0", tif.out_word64); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (tif.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", tif.in_ready); end
  endtask

  task automatic test_known_vector();
    logic a, d;
    logic [63:0] w;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 20) begin
      drive_cycle(1'b1, 64'h41EA3A0A_94BAA940, 128'd0, 1'b1, a, d, w);
      n++;
    end
    tif.in_valid = 1'b0;
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL kv_accept: got %b expected 1", a); end
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL kv_inflight_1: got %0d expected 1", inflight); end
    n = 0;
    while (!tif.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n !== ROUNDS) begin errors++; $display("FAIL kv_latency: got %0d expected %0d", n, ROUNDS); end
    drive_cycle(1'b0, 64'd0, 128'd0, 1'b1, a, d, w);
    checks++; if (d !== 1'b1 || w !== 64'd0) begin errors++; $display("FAIL kv_plaintext: got dlv=%b %h expected dlv=1 %h", d, w, 64'd0); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL kv_inflight_0: got %0d expected 0", inflight); end
    checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL kv_empty_valid: got %b expected 0", tif.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  pt[10], ct[10];
    logic [127:0] k[10];
    logic a, d;
    logic [63:0] w;
    int acc_n, dlv_n, cyc, idx;
    for (int i = 0; i < 10; i++) begin
      pt[i] = {$urandom, $urandom};
      k[i]  = rand_key();
      ct[i] = tea_enc(pt[i], k[i]);
    end
    acc_n = 0; dlv_n = 0; cyc = 0;
    while (dlv_n < 10 && cyc < 400) begin
      idx = (acc_n < 10) ? acc_n : 9;
      drive_cycle(acc_n < 10, ct[idx], k[idx], 1'b1, a, d, w);
      if (a) begin
        exp_q.push_back(pt[acc_n]);
        acc_n++;
        if (acc_n == NUM_LANES) begin
          checks++; if (cyc !== NUM_LANES - 1) begin errors++; $display("FAIL b2b_fill_cycle: got %0d expected %0d", cyc, NUM_LANES - 1); end
          checks++; if (tif.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", tif.in_ready); end
          checks++; if (inflight !== 4'(NUM_LANES)) begin errors++; $display("FAIL b2b_full_inflight: got %0d expected %0d", inflight, NUM_LANES); end
        end
      end
      if (d) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_spurious: got %h expected none", w); end
        else if (w !== exp_q[0]) begin errors++; $display("FAIL b2b_order: got %h expected %h", w, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
        dlv_n++;
      end
      cyc++;
    end
    tif.in_valid = 1'b0;
    checks++; if (dlv_n !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", dlv_n); end
  endtask

  task automatic test_backpressure();
    logic [63:0]  pt[8], ct[8];
    logic [127:0] k[8];
    logic a, d;
    logic [63:0] w, w0;
    int acc_n, dlv_n, cyc;
    for (int i = 0; i < 8; i++) begin
      pt[i] = {$urandom, $urandom};
      k[i]  = rand_key();
      ct[i] = tea_enc(pt[i], k[i]);
    end
    acc_n = 0; cyc = 0;
    while (acc_n < 8 && cyc < 50) begin
      drive_cycle(1'b1, ct[acc_n], k[acc_n], 1'b0, a, d, w);
      if (a) begin exp_q.push_back(pt[acc_n]); acc_n++; end
      cyc++;
    end
    tif.in_valid = 1'b0;
    cyc = 0;
    while (!tif.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (tif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", tif.out_valid); end
    checks++; if (tif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", tif.in_ready); end
    checks++; if (inflight !== 4'd8) begin errors++; $display("FAIL bp_inflight: got %0d expected 8", inflight); end
    w0 = tif.out_word64;
    checks++; if (w0 !== exp_q[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", w0, exp_q[0]); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, {$urandom, $urandom}, rand_key(), 1'b0, a, d, w);
      checks++; if (a !== 1'b0 || w !== w0 || inflight !== 4'd8) begin errors++; $display("FAIL bp_hold: got acc=%b %h inflight=%0d expected acc=0 %h inflight=8", a, w, inflight, w0); end
    end
    dlv_n = 0; cyc = 0;
    while (dlv_n < 8 && cyc < 50) begin
      drive_cycle(1'b0, 64'd0, 128'd0, 1'b1, a, d, w);
      if (d) begin
        checks++;
        if (w !== exp_q[0]) begin errors++; $display("FAIL bp_order: got %h expected %h", w, exp_q[0]); end
        void'(exp_q.pop_front());
        dlv_n++;
      end
      cyc++;
    end
    checks++; if (dlv_n !== 8 || inflight !== 4'd0) begin errors++; $display("FAIL bp_drain: got %0d delivered inflight=%0d expected 8 inflight=0", dlv_n, inflight); end
  endtask

  task automatic test_key_changes();
    logic [63:0]  pt[16], ct[16];
    logic [127:0] k[16];
    logic a, d, offering, ordy;
    logic [63:0] w;
    int acc_n, dlv_n, cyc;
    for (int i = 0; i < 16; i++) begin
      pt[i] = {$urandom, $urandom};
      k[i]  = rand_key();
      ct[i] = tea_enc(pt[i], k[i]);
    end
    acc_n = 0; dlv_n = 0; cyc = 0; offering = 1'b0;
    while (dlv_n < 16 && cyc < 2000) begin
      if (!offering && acc_n < 16) offering = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 6);
      if (offering) drive_cycle(1'b1, ct[acc_n], k[acc_n], ordy, a, d, w);
      else drive_cycle(1'b0, {$urandom, $urandom}, rand_key(), ordy, a, d, w);
      if (a) begin exp_q.push_back(pt[acc_n]); acc_n++; offering = 1'b0; end
      if (d) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL key_spurious: got %h expected none", w); end
        else if (w !== exp_q[0]) begin errors++; $display("FAIL key_plaintext: got %h expected %h", w, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
        dlv_n++;
      end
      checks++; if (inflight !== 4'(exp_q.size())) begin errors++; $display("FAIL key_inflight: got %0d expected %0d", inflight, exp_q.size()); end
      cyc++;
    end
    tif.in_valid = 1'b0;
    checks++; if (dlv_n !== 16) begin errors++; $display("FAIL key_count: got %0d expected 16", dlv_n); end
  endtask

  task automatic test_ena_pause();
    logic [63:0]  pt, ct;
    logic [127:0] k;
    logic a, d;
    logic [63:0] w;
    int n;
    pt = {$urandom, $urandom};
    k  = rand_key();
    ct = tea_enc(pt, k);
    n = 0; a = 1'b0;
    while (!a && n < 20) begin drive_cycle(1'b1, ct, k, 1'b1, a, d, w); n++; end
    tif.in_valid = 1'b0;
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL ena_accept: got %b expected 1", a); end
    repeat (10) begin @(posedge clk); #1; end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, {$urandom, $urandom}, rand_key(), 1'b1, a, d, w);
      checks++; if (a !== 1'b0 || d !== 1'b0 || inflight !== 4'd1) begin errors++; $display("FAIL ena_frozen: got acc=%b dlv=%b inflight=%0d expected 0 0 1", a, d, inflight); end
    end
    ena = 1'b1;
    tif.in_valid = 1'b0;
    n = 20;
    while (!tif.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (n !== ROUNDS + 10) begin errors++; $display("FAIL ena_latency: got %0d expected %0d", n, ROUNDS + 10); end
    drive_cycle(1'b0, 64'd0, 128'd0, 1'b1, a, d, w);
    checks++; if (d !== 1'b1 || w !== pt) begin errors++; $display("FAIL ena_plaintext: got dlv=%b %h expected dlv=1 %h", d, w, pt); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0]  pt, ct;
    logic [127:0] k;
    logic a, d;
    logic [63:0] w;
    int acc_n, cyc, stale;
    acc_n = 0; cyc = 0;
    while (acc_n < 5 && cyc < 30) begin
      pt = {$urandom, $urandom};
      k  = rand_key();
      drive_cycle(1'b1, tea_enc(pt, k), k, 1'b0, a, d, w);
      if (a) acc_n++;
      cyc++;
    end
    tif.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (inflight !== 4'd5) begin errors++; $display("FAIL rst_pre_inflight: got %0d expected 5", inflight); end
    rst = 1'b1;
    #2;
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL rst_inflight: got %0d expected 0", inflight); end
    checks++; if (tif.out_valid !== 1'b0 || tif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_handshake: got valid=%b ready=%b expected 0 0", tif.out_valid, tif.in_ready); end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, 64'd0, 128'd0, 1'b1, a, d, w);
      if (d) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_stale: got %0d deliveries expected 0", stale); end
    pt = {$urandom, $urandom};
    k  = rand_key();
    ct = tea_enc(pt, k);
    cyc = 0; a = 1'b0; d = 1'b0;
    while (!d && cyc < 100) begin
      drive_cycle(!a, ct, k, 1'b1, a, d, w);
      if (a) tif.in_valid = 1'b0;
      cyc++;
    end
    checks++; if (d !== 1'b1 || w !== pt) begin errors++; $display("FAIL rst_next_block: got dlv=%b %h expected dlv=1 %h", d, w, pt); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_key_changes();
    test_ena_pause();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
